// File: rtl/coax_rx_buffer_if.sv
// Bundle between the coax receiver / host controller and the receive frame buffer.
interface coax_rx_buffer_if #(
  parameter int DEPTH_BITS = 4
);
  logic                  rx_active;
  logic                  rx_error;
  logic [9:0]            rx_data;
  logic                  rx_strobe;
  logic                  clear;
  logic                  read_strobe;
  logic [11:0]           read_data;
  logic                  empty;
  logic                  full;
  logic [DEPTH_BITS:0]   count;
  logic                  overflow;

  modport master (
    output rx_active, rx_error, rx_data, rx_strobe, clear, read_strobe,
    input  read_data, empty, full, count, overflow
  );

  modport slave (
    input  rx_active, rx_error, rx_data, rx_strobe, clear, read_strobe,
    output read_data, empty, full, count, overflow
  );
endinterface

// File: rtl/coax_rx_buffer.sv
// Receive frame buffer: tags coax words with EOF/error flags and queues them in a
// first-word fall-through FIFO for the host controller.
module coax_rx_buffer #(
  parameter int DEPTH_BITS = 4
) (
  input logic              clk,
  input logic              reset_n,
  coax_rx_buffer_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_CNT = {1'b1, {DEPTH_BITS{1'b0}}};

  typedef struct packed {
    logic       err;
    logic       eof;
    logic [9:0] data;
  } entry_t;

  typedef enum logic [2:0] {IDLE, FRAME, FLUSH, ERROR_PUSH, ERROR_HOLD} state_t;

  state_t                state;
  logic                  prev_active, prev_error;
  logic                  hold_vld;
  logic [9:0]            hold;

  entry_t                mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_BITS:0]   cnt;
  logic                  ovf;

  logic                  act_fall, err_rise;
  logic                  push_req, push_ok, pop_ok;
  logic                  full_i, empty_i;
  entry_t                push_entry;

  assign act_fall = prev_active & ~bus.rx_active;
  assign err_rise = bus.rx_error & ~prev_error;
  assign full_i   = (cnt == FULL_CNT);
  assign empty_i  = (cnt == '0);

  // Push decode follows the FSM state; the last word of a frame waits in hold
  // until either another strobe or the frame end tells us whether it is EOF.
  always_comb begin
    push_req   = 1'b0;
    push_entry = '0;
    unique case (state)
      FRAME: if (!err_rise && !act_fall && bus.rx_strobe && hold_vld) begin
        push_req   = 1'b1;
        push_entry = {1'b0, 1'b0, hold};
      end
      FLUSH: if (hold_vld) begin
        push_req   = 1'b1;
        push_entry = {1'b0, 1'b1, hold};
      end
      ERROR_PUSH: begin
        push_req   = 1'b1;
        push_entry = {1'b1, 1'b1, bus.rx_data};
      end
      default: ;
    endcase
  end

  assign push_ok = push_req & ~full_i & ~bus.clear;
  assign pop_ok  = bus.read_strobe & ~empty_i & ~bus.clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      prev_active <= 1'b0;
      prev_error  <= 1'b0;
      hold_vld    <= 1'b0;
      hold        <= '0;
    end else begin
      // Edge history keeps tracking through clear so a still-high error is not re-seen.
      prev_active <= bus.rx_active;
      prev_error  <= bus.rx_error;
      if (bus.clear) begin
        state    <= IDLE;
        hold_vld <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (err_rise) begin
              state <= ERROR_PUSH;
            end else if (bus.rx_strobe) begin
              hold     <= bus.rx_data;
              hold_vld <= 1'b1;
              state    <= FRAME;
            end
          end
          FRAME: begin
            if (err_rise) begin
              hold_vld <= 1'b0;
              state    <= ERROR_PUSH;
            end else if (act_fall) begin
              state <= FLUSH;
            end else if (bus.rx_strobe) begin
              hold     <= bus.rx_data;
              hold_vld <= 1'b1;
            end
          end
          FLUSH: begin
            hold_vld <= 1'b0;
            state    <= IDLE;
          end
          ERROR_PUSH: state <= ERROR_HOLD;
          ERROR_HOLD: if (!bus.rx_error) state <= IDLE;
          default:    state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{DEPTH_BITS{1'b0}}, push_ok} - {{DEPTH_BITS{1'b0}}, pop_ok};
      if (push_req && full_i) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  assign bus.read_data = mem[rd_ptr];
  assign bus.empty     = empty_i;
  assign bus.full      = full_i;
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_coax_rx_buffer.sv
// Scoreboard bench for coax_rx_buffer: frame-level stimulus schedules expected entries,
// a monitor keeps a queue model of the FIFO and checks every cycle and every pop.
module tb_coax_rx_buffer;
  localparam int DB    = 4;
  localparam int DEPTH = 1 << DB;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  coax_rx_buffer_if #(.DEPTH_BITS(DB)) bus();
  coax_rx_buffer #(.DEPTH_BITS(DB)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    int          edge_n;
    logic [11:0] val;
  } sched_t;

  sched_t      sched[$];
  logic [11:0] model_q[$];
  logic        model_ovf;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          rd_prob = 0;
  int          force_rd_edge = -1;
  bit          done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks status each cycle, pops and compares the head when reading.
  initial begin
    bit          rs;
    bit          have;
    int          pre;
    logic [11:0] v;
    model_ovf       = 1'b0;
    bus.read_strobe = 1'b0;
    while (!done) begin
      @(negedge clk);
      chk("count", 32'(bus.count), model_q.size());
      chk("empty", 32'(bus.empty), 32'(model_q.size() == 0));
      chk("full", 32'(bus.full), 32'(model_q.size() == DEPTH));
      chk("overflow", 32'(bus.overflow), 32'(model_ovf));
      rs = (force_rd_edge == cyc + 1) || ($urandom_range(99) < rd_prob);
      bus.read_strobe = rs;
      if (rs && model_q.size() > 0) chk("read_data", 32'(bus.read_data), 32'(model_q[0]));
      @(posedge clk);
      cyc++;
      if (!reset_n || bus.clear) begin
        model_q.delete();
        sched.delete();
        model_ovf = 1'b0;
      end else begin
        pre  = model_q.size();
        have = 1'b0;
        v    = '0;
        if (sched.size() > 0 && sched[0].edge_n == cyc) begin
          have = 1'b1;
          v    = sched[0].val;
          void'(sched.pop_front());
        end
        if (rs && pre > 0) void'(model_q.pop_front());
        if (have) begin
          if (pre == DEPTH) model_ovf = 1'b1;
          else              model_q.push_back(v);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    bus.rx_strobe = 1'b0;
    bus.clear     = 1'b0;
  endtask

  task automatic strobe(input logic [9:0] w);
    tick();
    bus.rx_data   = w;
    bus.rx_strobe = 1'b1;
  endtask

  // One receiver frame: each word becomes an entry once its successor arrives,
  // the last is EOF two edges after active falls, an error replaces the held word.
  task automatic do_frame(input logic [9:0] words[$], input bit with_err,
                          input logic [9:0] code, input bit force_eof_rd);
    int n;
    n = words.size();
    tick();
    bus.rx_active = 1'b1;
    for (int j = 0; j < n; j++) begin
      strobe(words[j]);
      if (j > 0) sched.push_back('{edge_n: cyc + 1, val: {2'b00, words[j-1]}});
      repeat ($urandom_range(2, 1)) tick();
    end
    if (with_err) begin
      tick();
      bus.rx_error = 1'b1;
      bus.rx_data  = code;
      sched.push_back('{edge_n: cyc + 2, val: {2'b11, code}});
      repeat ($urandom_range(4, 2)) tick();
      bus.rx_error  = 1'b0;
      bus.rx_active = 1'b0;
      tick();
    end else begin
      tick();
      bus.rx_active = 1'b0;
      if (n > 0) begin
        sched.push_back('{edge_n: cyc + 2, val: {2'b01, words[n-1]}});
        if (force_eof_rd) force_rd_edge = cyc + 2;
      end
      tick();
    end
  endtask

  task automatic drain();
    int k;
    rd_prob = 100;
    k = 0;
    repeat (3) tick();
    while (!bus.empty && k < 100) begin
      tick();
      k++;
    end
    chk("drain_timeout", 32'(bus.empty), 32'd1);
    rd_prob = 0;
  endtask

  initial begin
    logic [9:0] wq[$];
    bus.rx_active = 1'b0;
    bus.rx_error  = 1'b0;
    bus.rx_data   = '0;
    bus.rx_strobe = 1'b0;
    bus.clear     = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_empty", 32'(bus.empty), 32'd1);
    chk("reset_count", 32'(bus.count), 32'd0);
    chk("reset_full", 32'(bus.full), 32'd0);
    chk("reset_overflow", 32'(bus.overflow), 32'd0);
    #1 reset_n = 1'b1;

    // Three-word frame.
    rd_prob = 0;
    wq = '{10'h101, 10'h002, 10'h3FF};
    do_frame(wq, 1'b0, '0, 1'b0);
    repeat (3) tick();
    chk("frame3_count", 32'(bus.count), 32'd3);
    chk("frame3_head", 32'(bus.read_data), 32'h101);
    drain();

    // Error after one strobe: held word discarded, single error entry.
    wq = '{10'($urandom)};
    do_frame(wq, 1'b1, 10'h002, 1'b0);
    repeat (2) tick();
    chk("err_count", 32'(bus.count), 32'd1);
    chk("err_head", 32'(bus.read_data), 32'hC02);
    drain();

    // Seventeen single-word frames with no reads.
    for (int f = 0; f < 17; f++) begin
      wq = '{10'($urandom)};
      do_frame(wq, 1'b0, '0, 1'b0);
    end
    repeat (3) tick();
    chk("ovf_full", 32'(bus.full), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd16);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);

    // Push and pop in the same cycle while full.
    wq = '{10'($urandom)};
    do_frame(wq, 1'b0, '0, 1'b1);
    repeat (3) tick();
    chk("fullpop_count", 32'(bus.count), 32'd15);
    chk("fullpop_ovf", 32'(bus.overflow), 32'd1);
    drain();
    tick();
    bus.clear = 1'b1;
    repeat (2) tick();
    chk("clear_ovf", 32'(bus.overflow), 32'd0);

    // Reads on an empty FIFO.
    rd_prob = 100;
    repeat (4) tick();
    rd_prob = 0;
    chk("emptyrd_empty", 32'(bus.empty), 32'd1);
    chk("emptyrd_count", 32'(bus.count), 32'd0);

    // Clear mid-frame after one entry was pushed.
    tick();
    bus.rx_active = 1'b1;
    wq = '{10'($urandom), 10'($urandom)};
    strobe(wq[0]);
    tick();
    strobe(wq[1]);
    sched.push_back('{edge_n: cyc + 1, val: {2'b00, wq[0]}});
    repeat (2) tick();
    chk("midclr_pre", 32'(bus.count), 32'd1);
    bus.clear = 1'b1;
    tick();
    bus.rx_active = 1'b0;
    repeat (4) tick();
    chk("midclr_empty", 32'(bus.empty), 32'd1);

    // Clear while an error is still high: no fresh edge, no new entry.
    tick();
    bus.rx_active = 1'b1;
    tick();
    bus.rx_error = 1'b1;
    bus.rx_data  = 10'h155;
    sched.push_back('{edge_n: cyc + 2, val: {2'b11, 10'h155}});
    repeat (2) tick();
    bus.clear = 1'b1;
    repeat (3) tick();
    bus.rx_error  = 1'b0;
    bus.rx_active = 1'b0;
    repeat (4) tick();
    chk("errclr_empty", 32'(bus.empty), 32'd1);

    // Asynchronous reset mid-frame with data buffered.
    tick();
    bus.rx_active = 1'b1;
    wq = '{10'($urandom), 10'($urandom)};
    strobe(wq[0]);
    tick();
    strobe(wq[1]);
    sched.push_back('{edge_n: cyc + 1, val: {2'b00, wq[0]}});
    tick();
    #2;
    reset_n = 1'b0;
    bus.rx_active = 1'b0;
    #1;
    chk("arst_empty", 32'(bus.empty), 32'd1);
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (3) tick();
    chk("arst_nopartial", 32'(bus.count), 32'd0);
    wq = '{10'h0AA, 10'h155};
    do_frame(wq, 1'b0, '0, 1'b0);
    repeat (3) tick();
    chk("arst_next", 32'(bus.count), 32'd2);
    drain();

    // Randomized frames with concurrent reads.
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(4, 0);
      wq.delete();
      for (int j = 0; j < n; j++) wq.push_back(10'($urandom));
      rd_prob = $urandom_range(90, 20);
      do_frame(wq, ($urandom_range(9) < 2), 10'($urandom), 1'b0);
    end
    drain();

    done = 1'b1;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
